// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C bus arbiter: FSM state encoding, byte type and
// the round-robin pointer helper.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OWNED      = 2'd1,
        FORCE_STOP = 2'd2
    } state_t;

    typedef logic [7:0] byte_t;

    localparam int IDX_W   = 3;   // owner/rr index width, covers up to 8 clients
    localparam int WD_W    = 24;  // watchdog counter width
    localparam int GUARD_W = 8;

    function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first asserted request found
// scanning upward from rr, wrapping at N_REQ.
module i2c_bus_arbiter_rr_picker
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] slot;

    // Scan offsets from the far end down so the smallest offset from rr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        slot  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, rr} + SW'(i);
            if (slot >= SW'(N_REQ)) begin
                slot = slot - SW'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (slot == SW'(j) && req[j]) begin
                    valid = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between N_REQ clients: round-robin grant held for a
// whole START..STOP transaction, with a watchdog that forces STOP on a stall.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int              N_REQ   = 2,
    parameter logic [WD_W-1:0] TIMEOUT = 24'd2000000,
    parameter int              GUARD   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    input  logic [N_REQ-1:0]   c_S,
    input  logic [N_REQ-1:0]   c_P,
    input  logic [N_REQ-1:0]   c_write,
    input  logic [N_REQ-1:0]   c_read,
    input  logic [8*N_REQ-1:0] c_wData,
    output logic [N_REQ-1:0]   c_rdy,
    output logic               c_ack,
    output byte_t              c_rData,
    output logic               m_S,
    output logic               m_P,
    output logic               m_write,
    output logic               m_read,
    output byte_t              m_wData,
    input  logic               m_rdy,
    input  logic               m_ack,
    input  byte_t              m_rData,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   owner,
    output state_t             state_dbg
);

    // Handshake: a command level (S/P/write/read) is held by the owner until
    // the master answers with rdy=1 in the same cycle; command and rdy both
    // high on a clock edge completes that command.

    state_t             state, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               inside_q, inside_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               terr_q, terr_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic               own_s, own_p, own_w, own_r, own_req, any_cmd;
    byte_t              own_wdata;
    logic [N_REQ-1:0]   own_hot;

    i2c_bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .rr    (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        own_s     = 1'b0;
        own_p     = 1'b0;
        own_w     = 1'b0;
        own_r     = 1'b0;
        own_req   = 1'b0;
        own_wdata = '0;
        own_hot   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_s      = c_S[i];
                own_p      = c_P[i];
                own_w      = c_write[i];
                own_r      = c_read[i];
                own_req    = req[i];
                own_wdata  = c_wData[8*i +: 8];
                own_hot[i] = 1'b1;
            end
        end
    end

    assign any_cmd = own_s | own_p | own_w | own_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            wd_q     <= '0;
            inside_q <= 1'b0;
            guard_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state    <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            wd_q     <= wd_d;
            inside_q <= inside_d;
            guard_q  <= guard_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner_q;
        rr_d     = rr_q;
        wd_d     = wd_q;
        inside_d = inside_q;
        guard_d  = '0;
        terr_d   = 1'b0;
        gnt      = '0;
        c_rdy    = '0;
        m_S      = 1'b0;
        m_P      = 1'b0;
        m_write  = 1'b0;
        m_read   = 1'b0;
        m_wData  = '0;

        case (state)
            IDLE: begin
                wd_d     = '0;
                inside_d = 1'b0;
                if (pick_valid) begin
                    state_d = OWNED;
                    owner_d = pick_idx;
                    rr_d    = next_rr(pick_idx, N_REQ);
                end
            end

            OWNED: begin
                gnt     = own_hot;
                c_rdy   = own_hot & {N_REQ{m_rdy}};
                m_S     = own_s;
                m_P     = own_p;
                m_write = own_w;
                m_read  = own_r;
                m_wData = own_wdata;

                if (own_s && m_rdy) inside_d = 1'b1;
                if (own_p && m_rdy) inside_d = 1'b0;

                if (any_cmd) begin
                    wd_d = '0;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + WD_W'(1);
                end

                // A client that dropped req mid-transaction keeps the bus
                // until its own STOP completes.
                if (!own_req && !inside_q && !any_cmd) begin
                    state_d = IDLE;
                end else if (!any_cmd && wd_q >= TIMEOUT - WD_W'(1)) begin
                    terr_d   = 1'b1;
                    inside_d = 1'b0;
                    state_d  = inside_q ? FORCE_STOP : IDLE;
                end
            end

            FORCE_STOP: begin
                m_P = 1'b1;
                // The master's rdy may still reflect the aborted command, so
                // it is ignored for GUARD cycles after P rises.
                if (guard_q != GUARD_W'(GUARD)) begin
                    guard_d = guard_q + GUARD_W'(1);
                end else begin
                    guard_d = guard_q;
                    if (m_rdy) state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign c_ack       = m_ack;
    assign c_rData     = m_rData;
    assign timeout_err = terr_q;
    assign owner       = owner_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: stimulus pushes time-stamped expected
// output snapshots; a negedge monitor pops one whenever the outputs change.
module tb_i2c_bus_arbiter;
    import i2c_bus_arbiter_pkg::*;

    localparam int N_REQ = 2;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] rdy;
        logic       terr;
        logic       ms;
        logic       mp;
        logic       mw;
        logic       mr;
        byte_t      wd;
        logic [2:0] own;
        state_t     st;
        logic       ack;
        byte_t      rd;
    } sig_t;

    localparam int SIG_W = $bits(sig_t);
    localparam int OBS_W = SIG_W + 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req, gnt, c_S, c_P, c_write, c_read, c_rdy;
    logic [8*N_REQ-1:0] c_wData;
    logic               c_ack, m_S, m_P, m_write, m_read, m_rdy, m_ack, timeout_err;
    byte_t              c_rData, m_wData, m_rData;
    logic [2:0]         owner;
    state_t             state_dbg;

    i2c_bus_arbiter #(.N_REQ(N_REQ), .TIMEOUT(24'd16), .GUARD(3)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .c_S(c_S), .c_P(c_P), .c_write(c_write), .c_read(c_read),
        .c_wData(c_wData), .c_rdy(c_rdy), .c_ack(c_ack), .c_rData(c_rData),
        .m_S(m_S), .m_P(m_P), .m_write(m_write), .m_read(m_read),
        .m_wData(m_wData), .m_rdy(m_rdy), .m_ack(m_ack), .m_rData(m_rData),
        .timeout_err(timeout_err), .owner(owner), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] exp_item;
    sig_t             e;
    sig_t             cur;
    sig_t             prev = '1;
    logic             mon_en = 1'b0;
    int               checks = 0;
    int               errors = 0;

    task automatic push(input int dc);
        exp_q.push_back({16'(cyc + dc), e});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur.gnt  = gnt;
            cur.rdy  = c_rdy;
            cur.terr = timeout_err;
            cur.ms   = m_S;
            cur.mp   = m_P;
            cur.mw   = m_write;
            cur.mr   = m_read;
            cur.wd   = m_wData;
            cur.own  = owner;
            cur.st   = state_dbg;
            cur.ack  = c_ack;
            cur.rd   = c_rData;
            if (cur !== prev) begin
                prev = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=none", cyc, cur);
                end else begin
                    exp_item = exp_q.pop_front();
                    if (exp_item !== {16'(cyc), cur}) begin
                        errors++;
                        $display("FAIL obs cyc=%0d got=%h required=%h at cyc=%0d",
                                 cyc, cur, exp_item[SIG_W-1:0], exp_item[OBS_W-1:SIG_W]);
                    end
                end
            end
        end
    end

    // driver
    initial begin
        rst = 1'b1; req = '0; c_S = '0; c_P = '0; c_write = '0; c_read = '0;
        c_wData = '0; m_rdy = 1'b0; m_ack = 1'b0; m_rData = '0;
        e = '0;

        // reset state
        tick(1);
        e.st = IDLE; push(0); mon_en = 1'b1;
        tick(2); rst = 1'b0;
        tick(2);

        // single client: S, write 0x52, read, P, release
        req = 2'b01; e.gnt = 2'b01; e.st = OWNED; e.own = 3'd0; push(1);
        tick(2); c_S[0] = 1'b1; e.ms = 1'b1; push(0);
        tick(1); m_rdy = 1'b1; e.rdy = 2'b01; push(0);
        tick(1); c_S[0] = 1'b0; m_rdy = 1'b0; c_write[0] = 1'b1; c_wData[7:0] = 8'h52;
        e.ms = 1'b0; e.rdy = 2'b00; e.mw = 1'b1; e.wd = 8'h52; push(0);
        tick(1); m_rdy = 1'b1; e.rdy = 2'b01; push(0);
        tick(1); c_write[0] = 1'b0; m_rdy = 1'b0; e.mw = 1'b0; e.rdy = 2'b00; push(0);
        tick(1); m_ack = 1'b1; m_rData = 8'hA5; c_read[0] = 1'b1;
        e.ack = 1'b1; e.rd = 8'hA5; e.mr = 1'b1; push(0);
        tick(1); c_read[0] = 1'b0; c_P[0] = 1'b1; e.mr = 1'b0; e.mp = 1'b1; push(0);
        tick(1); m_rdy = 1'b1; e.rdy = 2'b01; push(0);
        tick(1); c_P[0] = 1'b0; m_rdy = 1'b0; req = 2'b00; m_ack = 1'b0; m_rData = 8'h00;
        c_wData[7:0] = 8'h00;
        e.mp = 1'b0; e.rdy = 2'b00; e.ack = 1'b0; e.rd = 8'h00; e.wd = 8'h00; push(0);
        e.gnt = 2'b00; e.st = IDLE; push(1);

        // reset in the middle of client 1's write
        tick(2); req = 2'b10; e.gnt = 2'b10; e.st = OWNED; e.own = 3'd1; push(1);
        tick(2); c_write[1] = 1'b1; c_wData[15:8] = 8'h3C; e.mw = 1'b1; e.wd = 8'h3C; push(0);
        tick(1); rst = 1'b1; e = '0; e.st = IDLE; push(1);
        tick(1); rst = 1'b0; c_write[1] = 1'b0; c_wData[15:8] = 8'h00; req = 2'b00;

        // contention from reset, with non-owner isolation
        tick(2); req = 2'b11; e.gnt = 2'b01; e.st = OWNED; e.own = 3'd0; push(1);
        tick(2); c_write[1] = 1'b1; c_wData[15:8] = 8'hFF; c_wData[7:0] = 8'h11;
        e.wd = 8'h11; push(0);
        tick(1); m_rdy = 1'b1; e.rdy = 2'b01; push(0);
        tick(1); c_write[0] = 1'b1; e.mw = 1'b1; push(0);
        tick(1); c_write[0] = 1'b0; m_rdy = 1'b0; req[0] = 1'b0; c_wData[7:0] = 8'h00;
        e.mw = 1'b0; e.rdy = 2'b00; e.wd = 8'h00; push(0);
        e.gnt = 2'b00; e.st = IDLE; push(1);
        e.gnt = 2'b10; e.st = OWNED; e.own = 3'd1; e.mw = 1'b1; e.wd = 8'hFF; push(2);
        tick(3); c_write[1] = 1'b0; c_wData[15:8] = 8'h00; req = 2'b00;
        e.mw = 1'b0; e.wd = 8'h00; push(0);
        e.gnt = 2'b00; e.st = IDLE; push(1);
        tick(2); req = 2'b11; e.gnt = 2'b01; e.st = OWNED; e.own = 3'd0; push(1);
        tick(1); req = 2'b00; e.gnt = 2'b00; e.st = IDLE; push(1);

        // client 1 drops req after START; grant held until its STOP
        tick(2); req = 2'b10; e.gnt = 2'b10; e.st = OWNED; e.own = 3'd1; push(1);
        tick(2); c_S[1] = 1'b1; m_rdy = 1'b1; e.ms = 1'b1; e.rdy = 2'b10; push(0);
        tick(1); c_S[1] = 1'b0; m_rdy = 1'b0; req = 2'b00; e.ms = 1'b0; e.rdy = 2'b00; push(0);
        tick(3); c_P[1] = 1'b1; e.mp = 1'b1; push(0);
        tick(1); m_rdy = 1'b1; e.rdy = 2'b10; push(0);
        tick(1); c_P[1] = 1'b0; m_rdy = 1'b0; e.mp = 1'b0; e.rdy = 2'b00; push(0);
        e.gnt = 2'b00; e.st = IDLE; push(1);

        // watchdog inside a transaction: forced STOP, guard, then client 1
        tick(2); req = 2'b01; e.gnt = 2'b01; e.st = OWNED; e.own = 3'd0; push(1);
        tick(2); c_S[0] = 1'b1; m_rdy = 1'b1; e.ms = 1'b1; e.rdy = 2'b01; push(0);
        tick(1); c_S[0] = 1'b0; m_rdy = 1'b0; req = 2'b11; e.ms = 1'b0; e.rdy = 2'b00; push(0);
        e.gnt = 2'b00; e.terr = 1'b1; e.mp = 1'b1; e.st = FORCE_STOP; push(16);
        e.terr = 1'b0; push(17);
        e.mp = 1'b0; e.st = IDLE; push(20);
        e.gnt = 2'b10; e.own = 3'd1; e.st = OWNED; push(21);
        tick(16); m_rdy = 1'b1;
        tick(5); m_rdy = 1'b0; req = 2'b00; e.gnt = 2'b00; e.st = IDLE; push(1);

        // watchdog with no open transaction: straight back to IDLE
        tick(2); req = 2'b01; e.gnt = 2'b01; e.st = OWNED; e.own = 3'd0; push(1);
        e.gnt = 2'b00; e.st = IDLE; e.terr = 1'b1; push(17);
        e.terr = 1'b0; push(18);
        tick(17); req = 2'b00;

        // final report
        tick(4);
        while (exp_q.size() != 0) begin
            exp_item = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change got=none required=%h at cyc=%0d",
                     exp_item[SIG_W-1:0], exp_item[OBS_W-1:SIG_W]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
